apb_timer_slave: RTL and testbench

APB responder hosting a programmable down-counting timer with prescaler, auto-reload and interrupt.
- Sits behind the APB mux on the timer select line, as a peer of the existing register slaves.
- Is the responder end of the APB master's transfers.
- Inserts a configurable number of wait states on every access.
- Flags bad accesses with PSLVERR.

---
 rtl/apb_timer_slave_if.sv | 25 ++
 rtl/apb_timer_slave.sv | 179 +++++++++++++++++
 tb/tb_apb_timer_slave.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_timer_slave_if.sv
// APB bus bundle between the peripheral mux and the timer responder.
// Upper PADDR bits ride along but only the low nibble is decoded by the slave.
interface apb_timer_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_timer_slave.sv
// APB responder with a prescaled down-counting timer, auto-reload and level interrupt.
// Bus outputs are registered from next-state values so they reflect the RESP cycle contents.
module apb_timer_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 1,
  parameter int PRESCALE    = 4
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  apb_timer_slave_if.slave apb,
  output logic             irq
);

  localparam int                  PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]     PS_MAX = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0]     PS_ONE = PS_W'(1);
  localparam logic [DATA_WIDTH-1:0] ONE  = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] ZERO = {DATA_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [3:0]            wait_cnt_r, wait_cnt_nxt_s;
  logic                  en_r, auto_r, ie_r, expired_r;
  logic                  en_nxt_s, auto_nxt_s, ie_nxt_s, expired_nxt_s;
  logic [DATA_WIDTH-1:0] load_r, count_r, load_nxt_s, count_nxt_s;
  logic [PS_W-1:0]       presc_r, presc_nxt_s;
  logic [DATA_WIDTH-1:0] prdata_r, rd_data_s;
  logic                  pready_r, pslverr_r, irq_r;
  logic [3:0]            addr_s;
  logic                  err_s, commit_s, wr_ctrl_s, wr_load_s, wr_status_s;
  logic                  tick_s, expire_s, resp_nxt_s;
  logic                  unused_addr_s;

  assign unused_addr_s = ^apb.PADDR[ADDR_WIDTH-1:4];

  // Access FSM next state and wait-state counter
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (apb.PSEL && !apb.PENABLE) begin
          if (WAIT_STATES == 0) begin
            state_nxt_s = ST_RESP;
          end else begin
            state_nxt_s    = ST_WAIT;
            wait_cnt_nxt_s = 4'(WAIT_STATES);
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!apb.PSEL) begin
          state_nxt_s = ST_IDLE;
        end else if (apb.PENABLE) begin
          if (wait_cnt_r <= 4'd1) begin
            state_nxt_s    = ST_RESP;
            wait_cnt_nxt_s = 4'd0;
          end else begin
            wait_cnt_nxt_s = wait_cnt_r - 4'd1;
          end
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Address decode, error classification and write strobes
  always_comb begin
    addr_s = apb.PADDR[3:0];
    case (addr_s)
      4'h0, 4'h4, 4'hC: err_s = 1'b0;
      4'h8:             err_s = apb.PWRITE;
      default:          err_s = 1'b1;
    endcase
    commit_s    = (state_r == ST_RESP) && apb.PWRITE && !err_s;
    wr_ctrl_s   = commit_s && (addr_s == 4'h0);
    wr_load_s   = commit_s && (addr_s == 4'h4);
    wr_status_s = commit_s && (addr_s == 4'hC);
    resp_nxt_s  = (state_nxt_s == ST_RESP);
  end

  // Timer next state; bus writes take priority over timer events except W1C vs expiry
  always_comb begin
    tick_s   = en_r && (presc_r == PS_MAX);
    expire_s = tick_s && (count_r <= ONE);
    load_nxt_s = wr_load_s ? apb.PWDATA : load_r;
    if (wr_load_s) begin
      count_nxt_s = apb.PWDATA;
    end else if (expire_s) begin
      count_nxt_s = auto_r ? load_r : ZERO;
    end else if (tick_s) begin
      count_nxt_s = count_r - ONE;
    end else begin
      count_nxt_s = count_r;
    end
    if (wr_load_s || !en_r || tick_s) begin
      presc_nxt_s = {PS_W{1'b0}};
    end else begin
      presc_nxt_s = presc_r + PS_ONE;
    end
    if (wr_ctrl_s) begin
      en_nxt_s   = apb.PWDATA[0];
      auto_nxt_s = apb.PWDATA[1];
      ie_nxt_s   = apb.PWDATA[2];
    end else begin
      en_nxt_s   = (expire_s && !auto_r) ? 1'b0 : en_r;
      auto_nxt_s = auto_r;
      ie_nxt_s   = ie_r;
    end
    if (expire_s) begin
      expired_nxt_s = 1'b1;
    end else if (wr_status_s && apb.PWDATA[0]) begin
      expired_nxt_s = 1'b0;
    end else begin
      expired_nxt_s = expired_r;
    end
  end

  // Read mux over the values the registers will hold during RESP
  always_comb begin
    case (addr_s)
      4'h0:    rd_data_s = {{(DATA_WIDTH-3){1'b0}}, ie_nxt_s, auto_nxt_s, en_nxt_s};
      4'h4:    rd_data_s = load_nxt_s;
      4'h8:    rd_data_s = count_nxt_s;
      4'hC:    rd_data_s = {{(DATA_WIDTH-1){1'b0}}, expired_nxt_s};
      default: rd_data_s = ZERO;
    endcase
  end

  // State, timer and output registers
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= 4'd0;
      en_r       <= 1'b0;
      auto_r     <= 1'b0;
      ie_r       <= 1'b0;
      expired_r  <= 1'b0;
      load_r     <= ZERO;
      count_r    <= ZERO;
      presc_r    <= {PS_W{1'b0}};
      prdata_r   <= ZERO;
      pready_r   <= 1'b0;
      pslverr_r  <= 1'b0;
      irq_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      en_r       <= en_nxt_s;
      auto_r     <= auto_nxt_s;
      ie_r       <= ie_nxt_s;
      expired_r  <= expired_nxt_s;
      load_r     <= load_nxt_s;
      count_r    <= count_nxt_s;
      presc_r    <= presc_nxt_s;
      pready_r   <= resp_nxt_s;
      pslverr_r  <= resp_nxt_s && err_s;
      prdata_r   <= (resp_nxt_s && !err_s && !apb.PWRITE) ? rd_data_s : ZERO;
      irq_r      <= expired_r && ie_r;
    end
  end

  assign apb.PRDATA  = prdata_r;
  assign apb.PREADY  = pready_r;
  assign apb.PSLVERR = pslverr_r;
  assign irq         = irq_r;

endmodule

// File: tb/tb_apb_timer_slave.sv
// Randomised and directed bench for apb_timer_slave against a cycle-count model
// of the register file, timer and APB response timing.
module tb_apb_timer_slave;
  localparam int WS = 1;
  localparam int PS = 4;

  logic PCLK, PRESETn, irq;
  apb_timer_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_timer_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_STATES(WS), .PRESCALE(PS)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .apb(bus), .irq(irq)
  );

  int checks, errors;

  // model: register contents, timer phase, and progress of the current transfer
  logic [31:0] m_load, m_count;
  logic        m_en, m_auto, m_ie, m_exp, m_irq, m_busy;
  int          m_pre, m_acc;

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic errf(logic [31:0] a, logic w);
    logic [3:0] o;
    o = a[3:0];
    return !(o inside {4'h0, 4'h4, 4'h8, 4'hC}) || (w && o == 4'h8);
  endfunction

  function automatic logic [31:0] mread(logic [31:0] a);
    logic [3:0] o;
    o = a[3:0];
    if (o == 4'h0) return {29'd0, m_ie, m_auto, m_en};
    if (o == 4'h4) return m_load;
    if (o == 4'h8) return m_count;
    if (o == 4'hC) return {31'd0, m_exp};
    return 32'd0;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_load = 32'd0; m_count = 32'd0; m_en = 1'b0; m_auto = 1'b0; m_ie = 1'b0;
    m_exp = 1'b0; m_irq = 1'b0; m_busy = 1'b0; m_pre = 0; m_acc = 0;
  endtask

  task automatic compare();
    logic rsp, er;
    rsp = m_busy && (m_acc == WS);
    er  = errf(bus.PADDR, bus.PWRITE);
    check("pready", {31'd0, bus.PREADY}, {31'd0, rsp});
    check("pslverr", {31'd0, bus.PSLVERR}, {31'd0, rsp && er});
    check("prdata", bus.PRDATA, (rsp && !er && !bus.PWRITE) ? mread(bus.PADDR) : 32'd0);
    check("irq", {31'd0, irq}, {31'd0, m_irq});
  endtask

  // Advance one clock: predict from current inputs, cross the edge, check outputs.
  task automatic cycle();
    logic        resp_now, wr_ok, tick, expire;
    logic [3:0]  o;
    logic [31:0] n_load, n_count;
    logic        n_en, n_auto, n_ie, n_exp, n_irq, n_busy;
    int          n_pre, n_acc;
    o        = bus.PADDR[3:0];
    resp_now = m_busy && (m_acc == WS);
    wr_ok    = resp_now && bus.PWRITE && !errf(bus.PADDR, bus.PWRITE);
    tick     = m_en && (m_pre == PS - 1);
    expire   = tick && (m_count <= 32'd1);
    n_load = m_load; n_count = m_count; n_en = m_en; n_auto = m_auto; n_ie = m_ie;
    n_exp = m_exp; n_busy = m_busy; n_acc = m_acc;
    n_pre = (m_en && !tick) ? m_pre + 1 : 0;
    n_irq = m_exp && m_ie;
    if (expire) begin
      n_exp = 1'b1;
      if (m_auto) n_count = m_load;
      else begin n_count = 32'd0; n_en = 1'b0; end
    end else if (tick) begin
      n_count = m_count - 32'd1;
    end
    if (wr_ok) begin
      if (o == 4'h0) begin
        n_en = bus.PWDATA[0]; n_auto = bus.PWDATA[1]; n_ie = bus.PWDATA[2];
      end
      if (o == 4'h4) begin n_load = bus.PWDATA; n_count = bus.PWDATA; n_pre = 0; end
      if (o == 4'hC && bus.PWDATA[0] && !expire) n_exp = 1'b0;
    end
    if (resp_now) n_busy = 1'b0;
    else if (m_busy) begin
      if (!bus.PSEL) n_busy = 1'b0;
      else if (bus.PENABLE) n_acc = m_acc + 1;
    end else if (bus.PSEL && !bus.PENABLE) begin
      n_busy = 1'b1; n_acc = 0;
    end
    @(posedge PCLK);
    if (!PRESETn) model_reset();
    else begin
      m_load = n_load; m_count = n_count; m_en = n_en; m_auto = n_auto; m_ie = n_ie;
      m_exp = n_exp; m_irq = n_irq; m_busy = n_busy; m_pre = n_pre; m_acc = n_acc;
    end
    @(negedge PCLK);
    compare();
  endtask

  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input bit abort,
                      output logic [31:0] rdata, output logic err, output int waits);
    rdata = 32'd0; err = 1'b0; waits = 0;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = w; bus.PADDR = a; bus.PWDATA = d;
    cycle();
    if (abort) begin
      bus.PSEL = 1'b0;
      cycle();
      bus.PWRITE = 1'b0;
      return;
    end
    bus.PENABLE = 1'b1;
    while (bus.PREADY !== 1'b1 && waits < 20) begin
      cycle();
      waits++;
    end
    check("xfer_ready", {31'd0, bus.PREADY}, 32'd1);
    rdata = bus.PRDATA;
    err   = bus.PSLVERR;
    cycle();
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, output logic err);
    logic [31:0] r;
    int          w;
    xfer(1'b1, a, d, 1'b0, r, err, w);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic err);
    int w;
    xfer(1'b0, a, 32'd0, 1'b0, d, err, w);
  endtask

  // Idle until the next transfer's commit edge lands on a tick (optionally with COUNT == 1).
  task automatic align(input bit need_one);
    int guard;
    guard = 0;
    while (!((m_pre == PS - 2 - WS) && (!need_one || m_count == 32'd1)) && guard < 64) begin
      cycle();
      guard++;
    end
    check("align_budget", {31'd0, guard < 64}, 32'd1);
  endtask

  initial begin
    logic [31:0] d, a, data;
    logic        e;
    int          w, sel, gap;
    checks = 0; errors = 0;
    PRESETn = 1'b0;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 32'd0; bus.PWDATA = 32'd0;
    model_reset();
    @(negedge PCLK);
    repeat (3) cycle();
    PRESETn = 1'b1;
    check("rst_pready", {31'd0, bus.PREADY}, 32'd0);
    check("rst_prdata", bus.PRDATA, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    cycle();

    // basic write/read with one wait state
    wr(32'h4, 32'd5, e);
    check("load_err", {31'd0, e}, 32'd0);
    xfer(1'b0, 32'h8, 32'd0, 1'b0, d, e, w);
    check("count_rd", d, 32'd5);
    check("count_rd_err", {31'd0, e}, 32'd0);
    check("wait_cycles", w, 32'd1);

    // one-shot: 3 ticks of 4 cycles, irq one cycle after the flag
    wr(32'h0, 32'h5, e);
    wr(32'h4, 32'd3, e);
    repeat (12) cycle();
    check("oneshot_irq_early", {31'd0, irq}, 32'd0);
    cycle();
    check("oneshot_irq", {31'd0, irq}, 32'd1);
    rd(32'h8, d, e); check("oneshot_count", d, 32'd0);
    rd(32'hC, d, e); check("oneshot_status", d, 32'd1);
    rd(32'h0, d, e); check("oneshot_ctrl", d, 32'h4);

    // auto-reload with interrupt, W1C semantics
    wr(32'hC, 32'd1, e);
    wr(32'h0, 32'h7, e);
    wr(32'h4, 32'd2, e);
    repeat (8) cycle();
    check("auto_irq_early", {31'd0, irq}, 32'd0);
    cycle();
    check("auto_irq", {31'd0, irq}, 32'd1);
    wr(32'hC, 32'd0, e);
    rd(32'hC, d, e); check("w0_keeps", d, 32'd1);
    wr(32'h0, 32'h0, e);
    wr(32'hC, 32'd1, e);
    rd(32'hC, d, e); check("w1c_clears", d, 32'd0);

    // error responses
    rd(32'h2, d, e);
    check("unaligned_err", {31'd0, e}, 32'd1);
    check("unaligned_data", d, 32'd0);
    wr(32'hE, 32'h1, e);
    check("badoff_err", {31'd0, e}, 32'd1);
    wr(32'h8, 32'hDEAD, e);
    check("count_wr_err", {31'd0, e}, 32'd1);
    rd(32'h8, d, e);
    check("count_kept", d, m_count);
    check("count_not_dead", {31'd0, d == 32'hDEAD}, 32'd0);

    // collisions on the tick edge
    wr(32'h0, 32'h3, e);
    wr(32'h4, 32'd2, e);
    align(1'b1);
    wr(32'hC, 32'd1, e);
    rd(32'hC, d, e); check("set_beats_w1c", d, 32'd1);
    align(1'b0);
    wr(32'h4, 32'd9, e);
    rd(32'h8, d, e); check("load_beats_tick", d, 32'd9);
    wr(32'h0, 32'h0, e);

    // reset during the wait state of a LOAD write
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 32'h4; bus.PWDATA = 32'd7;
    cycle();
    bus.PENABLE = 1'b1;
    #2 PRESETn = 1'b0;
    #1;
    check("arst_pready", {31'd0, bus.PREADY}, 32'd0);
    check("arst_pslverr", {31'd0, bus.PSLVERR}, 32'd0);
    check("arst_prdata", bus.PRDATA, 32'd0);
    check("arst_irq", {31'd0, irq}, 32'd0);
    model_reset();
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    cycle(); cycle();
    PRESETn = 1'b1;
    cycle();
    rd(32'h4, d, e); check("load_after_rst", d, 32'd0);
    wr(32'h4, 32'd7, e);
    rd(32'h4, d, e); check("load_post_rst", d, 32'd7);

    // randomised traffic, including aborts, aliases and back-to-back transfers
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4) a = 32'(sel * 4);
      else if (sel == 4) a = 32'($urandom_range(0, 15));
      else a = 32'($urandom_range(0, 3) * 4);
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_FFF0);
      case (a[3:0])
        4'h0:    data = 32'($urandom_range(0, 7));
        4'h4:    data = 32'($urandom_range(0, 6));
        4'hC:    data = 32'($urandom_range(0, 3));
        default: data = $urandom;
      endcase
      xfer(1'($urandom_range(0, 1)), a, data, $urandom_range(0, 9) == 0, d, e, w);
      gap = $urandom_range(0, 2);
      repeat (gap) cycle();
    end
    repeat (20) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
